// File: rtl/tank_model.sv
// -----------------------------------------------------------------------------
// tank_model
// Behavioural water-tank model that closes the loop around the pump-sequencing
// FSM. A saturating level register integrates pump inflow and consumer outflow
// once per prescaled tick. Registered threshold comparators derive the lower (I)
// and upper (S) level sensors from that register.
//
// Optional feature: define TANK_MODEL_ALARM_EN to build the sticky overflow/dry
// alarm flops. When the macro is undefined, both alarm outputs are tied to 0.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   synchronous, active-low
//   pumps[1:0]     in   bit0 = pump B1 on, bit1 = pump B2 on
//   demand         in   consumer draw active
//   load           in   force level to load_value this cycle
//   load_value     in   preset level for load
//   level_sensors  out  bit0 = I (lower), bit1 = S (upper), registered
//   level          out  current level register
//   tick           out  high in the cycle whose closing edge updates the level
//   overflow_alarm out  sticky: sum saturated at the top
//   dry_alarm      out  sticky: sum saturated at zero
// -----------------------------------------------------------------------------
module tank_model #(
    parameter int LEVEL_WIDTH = 8,
    parameter int LOW_MARK    = 64,
    parameter int HIGH_MARK   = 192,
    parameter int FILL_RATE   = 2,
    parameter int DRAIN_RATE  = 1,
    parameter int TICK_DIV    = 4,
    parameter int INIT_LEVEL  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             pumps,
    input  logic                   demand,
    input  logic                   load,
    input  logic [LEVEL_WIDTH-1:0] load_value,
    output logic [1:0]             level_sensors,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   tick,
    output logic                   overflow_alarm,
    output logic                   dry_alarm
);

    // Three guard bits hold the inflow headroom and the sign of an underflow.
    localparam int SUM_W = LEVEL_WIDTH + 3;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic signed [SUM_W-1:0]   LEVEL_MAX  = SUM_W'((1 << LEVEL_WIDTH) - 1);
    localparam logic [LEVEL_WIDTH-1:0]    LOW_L      = LEVEL_WIDTH'(LOW_MARK);
    localparam logic [LEVEL_WIDTH-1:0]    HIGH_L     = LEVEL_WIDTH'(HIGH_MARK);
    localparam logic [LEVEL_WIDTH-1:0]    INIT_L     = LEVEL_WIDTH'(INIT_LEVEL);
    localparam logic [CNT_W-1:0]          DIV_LAST   = CNT_W'(TICK_DIV - 1);

    // Clamp the signed sum into the representable level range.
    function automatic logic [LEVEL_WIDTH-1:0] sat_level(input logic signed [SUM_W-1:0] s);
        if (s < 0)
            sat_level = '0;
        else if (s > LEVEL_MAX)
            sat_level = '1;
        else
            sat_level = s[LEVEL_WIDTH-1:0];
    endfunction

    logic [CNT_W-1:0]         div_cnt;
    logic [1:0]               pump_cnt;
    logic signed [SUM_W-1:0]  level_s;
    logic signed [SUM_W-1:0]  fill_s;
    logic signed [SUM_W-1:0]  drain_s;
    logic signed [SUM_W-1:0]  sum_p0;

    // Prescaler: wraps at TICK_DIV-1. With TICK_DIV = 1 it is stuck at 0, so
    // tick stays high.
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clock) begin
        if (!reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // ---- stage p0: unsaturated next-level sum (combinational) ----
    always_comb begin
        pump_cnt = {1'b0, pumps[0]} + {1'b0, pumps[1]};
        level_s  = signed'(SUM_W'(level));
        fill_s   = signed'(SUM_W'(FILL_RATE * pump_cnt));
        drain_s  = demand ? signed'(SUM_W'(DRAIN_RATE)) : '0;
        sum_p0   = level_s + fill_s - drain_s;
    end

    // ---- level register: reset > load > tick update > hold ----
    always_ff @(posedge clock) begin
        if (!reset)
            level <= INIT_L;
        else if (load)
            level <= load_value;
        else if (tick)
            level <= sat_level(sum_p0);
    end

    // ---- sensor stage: one cycle behind the level register ----
    always_ff @(posedge clock) begin
        if (!reset)
            level_sensors <= 2'b00;
        else
            level_sensors <= {(level >= HIGH_L), (level >= LOW_L)};
    end

`ifdef TANK_MODEL_ALARM_EN
    // Alarms fire only when the saturating update is actually applied, so a
    // tick pre-empted by load does not raise them. Only reset clears them.
    logic update_en;
    assign update_en = tick && !load;

    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow_alarm <= 1'b0;
            dry_alarm      <= 1'b0;
        end else begin
            if (update_en && (sum_p0 > LEVEL_MAX))
                overflow_alarm <= 1'b1;
            if (update_en && (sum_p0 < 0))
                dry_alarm <= 1'b1;
        end
    end
`else
    assign overflow_alarm = 1'b0;
    assign dry_alarm      = 1'b0;
`endif

endmodule
